// File: rtl/sdram_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sdram_pkg
// Brief   : Shared SDRAM controller command/state encodings and arbiter states.
// Revision: 1.0 - initial release
// ============================================================================
package sdram_pkg;

  // Command encoding is {cs_n, ras_n, cas_n, we_n}
  typedef enum logic [3:0] {
    CMD_MRS   = 4'b0000,
    CMD_REF   = 4'b0001,
    CMD_PRE   = 4'b0010,
    CMD_ACT   = 4'b0011,
    CMD_WRITE = 4'b0100,
    CMD_READ  = 4'b0101,
    CMD_BST   = 4'b0110,
    CMD_NOP   = 4'b0111,
    CMD_DESL  = 4'b1111
  } sdram_cmd_e;

  typedef enum logic [2:0] {
    CTL_INIT      = 3'd0,
    CTL_IDLE      = 3'd1,
    CTL_ACTIVATE  = 3'd2,
    CTL_RW        = 3'd3,
    CTL_PRECHARGE = 3'd4,
    CTL_REFRESH   = 3'd5
  } sdram_ctl_state_e;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_BUSY  = 2'd2
  } arb_state_e;

  localparam logic ARB_PORT0 = 1'b0;
  localparam logic ARB_PORT1 = 1'b1;

endpackage
`default_nettype wire

// File: rtl/sdram_arb_sel.sv
`default_nettype none
// ============================================================================
// Module  : sdram_arb_sel
// Brief   : Two-input selector; prio names the port that wins a tie.
// Revision: 1.0 - initial release
// ============================================================================
module sdram_arb_sel
  import sdram_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic prio,
  output logic valid,
  output logic gnt
);

  always_comb begin
    valid = req0 | req1;
    if (req0 && req1) begin
      gnt = prio;
    end else if (req1) begin
      gnt = ARB_PORT1;
    end else begin
      gnt = ARB_PORT0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : sdram_arbiter
// Brief   : Two-port arbiter in front of an SDRAM controller core, one
//           transaction outstanding. Define SDRAM_ARB_RR_EN for round-robin,
//           otherwise port 0 has fixed priority.
// Revision: 1.0 - initial release
// ============================================================================
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 25,
  parameter int WORD_LEN   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p0_rd,
  input  logic [WORD_LEN-1:0]   p0_wr,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  output logic                  p0_rdy,
  output logic                  p0_rvalid,
  output logic                  p0_wvalid,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  input  logic                  p1_rd,
  input  logic [WORD_LEN-1:0]   p1_wr,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p1_rdy,
  output logic                  p1_rvalid,
  output logic                  p1_wvalid,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic                  m_rd,
  output logic [WORD_LEN-1:0]   m_wr,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_wdata,
  input  logic                  m_rdy,
  input  logic                  m_rvalid,
  input  logic                  m_wvalid,
  input  logic [DATA_WIDTH-1:0] m_rdata
);

  arb_state_e state_q, state_d;
  logic       owner_q, owner_d;
  logic       req0, req1, own_req;
  logic       sel_valid, sel_gnt, prio;

  assign req0    = p0_rd | (|p0_wr);
  assign req1    = p1_rd | (|p1_wr);
  assign own_req = (owner_q == ARB_PORT1) ? req1 : req0;

`ifdef SDRAM_ARB_RR_EN
  // Last granted port; resets to port 1 so that port 0 wins the first tie.
  logic last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= ARB_PORT1;
    end else if (state_q == ARB_IDLE && sel_valid) begin
      last_q <= sel_gnt;
    end
  end

  assign prio = ~last_q;
`else
  assign prio = ARB_PORT0;
`endif

  sdram_arb_sel u_sel (
    .req0  (req0),
    .req1  (req1),
    .prio  (prio),
    .valid (sel_valid),
    .gnt   (sel_gnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      owner_q <= ARB_PORT0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    m_rd      = 1'b0;
    m_wr      = '0;
    m_addr    = '0;
    m_wdata   = '0;
    p0_rdy    = 1'b0;
    p1_rdy    = 1'b0;
    p0_rvalid = 1'b0;
    p0_wvalid = 1'b0;
    p0_rdata  = '0;
    p1_rvalid = 1'b0;
    p1_wvalid = 1'b0;
    p1_rdata  = '0;

    // Outputs are forced quiet for the whole reset cycle, whatever the state.
    if (!rst) begin
      case (state_q)
        ARB_IDLE: begin
          if (sel_valid) begin
            state_d = ARB_GRANT;
            owner_d = sel_gnt;
          end
        end
        ARB_GRANT: begin
          if (!own_req) begin
            state_d = ARB_IDLE;
          end else begin
            if (owner_q == ARB_PORT1) begin
              m_rd    = p1_rd;
              m_wr    = p1_wr;
              m_addr  = p1_addr;
              m_wdata = p1_wdata;
              p1_rdy  = m_rdy;
            end else begin
              m_rd    = p0_rd;
              m_wr    = p0_wr;
              m_addr  = p0_addr;
              m_wdata = p0_wdata;
              p0_rdy  = m_rdy;
            end
            if (m_rdy) begin
              state_d = ARB_BUSY;
            end
          end
        end
        ARB_BUSY: begin
          if (owner_q == ARB_PORT1) begin
            p1_rvalid = m_rvalid;
            p1_wvalid = m_wvalid;
            p1_rdata  = m_rvalid ? m_rdata : '0;
          end else begin
            p0_rvalid = m_rvalid;
            p0_wvalid = m_wvalid;
            p0_rdata  = m_rvalid ? m_rdata : '0;
          end
          if (m_rvalid || m_wvalid) begin
            state_d = ARB_IDLE;
          end
        end
        default: begin
          state_d = ARB_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
